control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 78 +++++++
 rtl/control_sequencer_if.sv | 46 ++++
 rtl/control_sequencer_decoder.sv | 100 ++++++++++
 rtl/control_sequencer.sv | 102 ++++++++++
 tb/tb_control_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: opcodes, ALU encodings, FSM states, instruction and control words.
// Optional shift support is enabled with the CTRL_SEQ_SHIFT_EN macro.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDI = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_LD  = 4'd8,
    OP_ST  = 4'd9
  } opcode_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_STEP1   = 3'd1;
  localparam state_t ST_STEP2   = 3'd2;
  localparam state_t ST_STEP3   = 3'd3;
  localparam state_t ST_ILLEGAL = 3'd4;

  typedef struct packed {
    opcode_e    opcode;
    logic       rd;
    logic       rs;
    logic [7:0] imm;
  } instr_t;

  typedef struct packed {
    logic       alu_oe;
    logic       alu_sub;
    logic [1:0] alu_op;
    logic       alu_bwr;
    logic       alu_shift_left;
    logic       reg_wr0;
    logic       reg_wr1;
    logic       reg_bus_sel;
    logic       reg_bus_en;
    logic       alu_sel;
    logic       ram_addr_en;
    logic       ram_write_en;
    logic       ram_read_sel;
    logic       ram_oe;
    logic       bus_drive;
    logic [7:0] bus_value;
    logic       done;
  } ctrl_t;

  function automatic logic is_legal(input opcode_e op);
    case (op)
      OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST: is_legal = 1'b1;
`ifdef CTRL_SEQ_SHIFT_EN
      OP_SHR, OP_SHL: is_legal = 1'b1;
`else
      OP_SHR, OP_SHL: is_legal = 1'b0;
`endif
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] step_count(input opcode_e op);
    case (op)
      OP_NOP, OP_LDI: step_count = 2'd1;
      OP_LD, OP_ST:   step_count = 2'd2;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: step_count = 2'd3;
      default: step_count = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction handshake, ALU flag inputs and datapath control outputs of the control sequencer.
interface control_sequencer_if;
  logic        i_instrValid;
  logic [15:0] i_instr;
  logic        o_instrReady;
  logic        i_aluFlagN;
  logic        i_aluFlagZ;
  logic        o_ctrlAluOE;
  logic        o_ctrlAluSub;
  logic [1:0]  o_ctrlAluOp;
  logic        o_ctrlAluBWr;
  logic        o_ctrlAluShiftLeft;
  logic        o_ctrlRegWr0;
  logic        o_ctrlRegWr1;
  logic        o_ctrlRegBusSel;
  logic        o_ctrlRegBusEn;
  logic        o_ctrlAluSel;
  logic        o_ctrlRamAddressEn;
  logic        o_ctrlRamWriteEn;
  logic        o_ctrlRamReadDataSelect;
  logic        o_ctrlRamOE;
  logic [7:0]  o_busValue;
  logic        o_busDrive;
  logic        o_done;
  logic        o_illegal;
  logic        o_flagN;
  logic        o_flagZ;

  modport master (
    output i_instrValid, i_instr, i_aluFlagN, i_aluFlagZ,
    input  o_instrReady, o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluOp, o_ctrlAluBWr,
           o_ctrlAluShiftLeft, o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel,
           o_ctrlRegBusEn, o_ctrlAluSel, o_ctrlRamAddressEn, o_ctrlRamWriteEn,
           o_ctrlRamReadDataSelect, o_ctrlRamOE, o_busValue, o_busDrive,
           o_done, o_illegal, o_flagN, o_flagZ
  );

  modport slave (
    input  i_instrValid, i_instr, i_aluFlagN, i_aluFlagZ,
    output o_instrReady, o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluOp, o_ctrlAluBWr,
           o_ctrlAluShiftLeft, o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel,
           o_ctrlRegBusEn, o_ctrlAluSel, o_ctrlRamAddressEn, o_ctrlRamWriteEn,
           o_ctrlRamReadDataSelect, o_ctrlRamOE, o_busValue, o_busDrive,
           o_done, o_illegal, o_flagN, o_flagZ
  );
endinterface

// File: rtl/control_sequencer_decoder.sv
// control_decoder: combinational opcode + step -> control word. Non-step states decode to all zeros.
// SHL only sets the shift-left control when CTRL_SEQ_SHIFT_EN is defined.
module control_decoder
  import control_sequencer_pkg::*;
(
  input  instr_t instr_i,
  input  state_t step_i,
  output ctrl_t  ctrl_o
);

  // Control word for the step about to execute
  always_comb begin
    ctrl_o = '0;
    case (instr_i.opcode)
      OP_NOP: begin
        ctrl_o.done = (step_i == ST_STEP1);
      end
      OP_LDI: begin
        if (step_i == ST_STEP1) begin
          ctrl_o.bus_drive = 1'b1;
          ctrl_o.bus_value = instr_i.imm;
          ctrl_o.reg_wr0   = ~instr_i.rd;
          ctrl_o.reg_wr1   = instr_i.rd;
          ctrl_o.done      = 1'b1;
        end else begin
          ctrl_o.done = 1'b0;
        end
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
        case (step_i)
          ST_STEP1: begin
            ctrl_o.bus_drive = 1'b1;
            ctrl_o.bus_value = instr_i.imm;
            ctrl_o.alu_bwr   = 1'b1;
            ctrl_o.alu_sel   = instr_i.rs;
          end
          ST_STEP2, ST_STEP3: begin
            ctrl_o.alu_sel = instr_i.rs;
            ctrl_o.alu_sub = (instr_i.opcode == OP_SUB);
            case (instr_i.opcode)
              OP_AND:         ctrl_o.alu_op = ALU_AND;
              OP_OR:          ctrl_o.alu_op = ALU_OR;
              OP_SHR, OP_SHL: ctrl_o.alu_op = ALU_SHIFT;
              default:        ctrl_o.alu_op = ALU_ADD;
            endcase
`ifdef CTRL_SEQ_SHIFT_EN
            ctrl_o.alu_shift_left = (instr_i.opcode == OP_SHL);
`else
            ctrl_o.alu_shift_left = 1'b0;
`endif
            if (step_i == ST_STEP3) begin
              ctrl_o.alu_oe  = 1'b1;
              ctrl_o.reg_wr0 = ~instr_i.rd;
              ctrl_o.reg_wr1 = instr_i.rd;
              ctrl_o.done    = 1'b1;
            end else begin
              ctrl_o.done = 1'b0;
            end
          end
          default: ctrl_o = '0;
        endcase
      end
      OP_ST: begin
        case (step_i)
          ST_STEP1: begin
            ctrl_o.reg_bus_sel = instr_i.rd;
            ctrl_o.reg_bus_en  = 1'b1;
            ctrl_o.ram_addr_en = 1'b1;
          end
          ST_STEP2: begin
            ctrl_o.reg_bus_sel  = instr_i.rs;
            ctrl_o.reg_bus_en   = 1'b1;
            ctrl_o.ram_write_en = 1'b1;
            ctrl_o.done         = 1'b1;
          end
          default: ctrl_o = '0;
        endcase
      end
      OP_LD: begin
        case (step_i)
          ST_STEP1: begin
            ctrl_o.reg_bus_sel = instr_i.rs;
            ctrl_o.reg_bus_en  = 1'b1;
            ctrl_o.ram_addr_en = 1'b1;
          end
          ST_STEP2: begin
            ctrl_o.ram_read_sel = 1'b1;
            ctrl_o.ram_oe       = 1'b1;
            ctrl_o.reg_wr0      = ~instr_i.rd;
            ctrl_o.reg_wr1      = instr_i.rd;
            ctrl_o.done         = 1'b1;
          end
          default: ctrl_o = '0;
        endcase
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-step instruction sequencer: accepts one instruction in IDLE and drives registered datapath controls.
// Build with CTRL_SEQ_SHIFT_EN to execute SHR/SHL; otherwise they are treated as illegal opcodes.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  control_sequencer_if.slave  bus
);

  state_t     state_q, state_d;
  instr_t     instr_q, instr_d;
  ctrl_t      ctrl_d, ctrl_q;
  logic       ready_q, illegal_q, flag_n_q, flag_z_q;
  logic [1:0] unused_pad_s;

  assign unused_pad_s = bus.i_instr[9:8];

  // Next state and instruction latch; fields only change on acceptance
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_instrValid) begin
          instr_d.opcode = opcode_e'(bus.i_instr[15:12]);
          instr_d.rd     = bus.i_instr[11];
          instr_d.rs     = bus.i_instr[10];
          instr_d.imm    = bus.i_instr[7:0];
          state_d        = is_legal(instr_d.opcode) ? ST_STEP1 : ST_ILLEGAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP1, ST_STEP2, ST_STEP3: begin
        if (state_q[1:0] == step_count(instr_q.opcode)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q + 3'd1;
        end
      end
      ST_ILLEGAL: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Decoding the upcoming step lets the control outputs be registered with no added latency
  control_decoder u_decoder (
    .instr_i (instr_d),
    .step_i  (state_d),
    .ctrl_o  (ctrl_d)
  );

  // State, latched instruction, registered outputs and ALU flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      ctrl_q    <= '0;
      ready_q   <= 1'b1;
      illegal_q <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ctrl_q    <= ctrl_d;
      ready_q   <= (state_d == ST_IDLE);
      illegal_q <= (state_d == ST_ILLEGAL);
      if (state_q == ST_STEP3) begin
        flag_n_q <= bus.i_aluFlagN;
        flag_z_q <= bus.i_aluFlagZ;
      end else begin
        flag_n_q <= flag_n_q;
        flag_z_q <= flag_z_q;
      end
    end
  end

  assign bus.o_instrReady            = ready_q;
  assign bus.o_ctrlAluOE             = ctrl_q.alu_oe;
  assign bus.o_ctrlAluSub            = ctrl_q.alu_sub;
  assign bus.o_ctrlAluOp             = ctrl_q.alu_op;
  assign bus.o_ctrlAluBWr            = ctrl_q.alu_bwr;
  assign bus.o_ctrlAluShiftLeft      = ctrl_q.alu_shift_left;
  assign bus.o_ctrlRegWr0            = ctrl_q.reg_wr0;
  assign bus.o_ctrlRegWr1            = ctrl_q.reg_wr1;
  assign bus.o_ctrlRegBusSel         = ctrl_q.reg_bus_sel;
  assign bus.o_ctrlRegBusEn          = ctrl_q.reg_bus_en;
  assign bus.o_ctrlAluSel            = ctrl_q.alu_sel;
  assign bus.o_ctrlRamAddressEn      = ctrl_q.ram_addr_en;
  assign bus.o_ctrlRamWriteEn        = ctrl_q.ram_write_en;
  assign bus.o_ctrlRamReadDataSelect = ctrl_q.ram_read_sel;
  assign bus.o_ctrlRamOE             = ctrl_q.ram_oe;
  assign bus.o_busDrive              = ctrl_q.bus_drive;
  assign bus.o_busValue              = ctrl_q.bus_value;
  assign bus.o_done                  = ctrl_q.done;
  assign bus.o_illegal               = illegal_q;
  assign bus.o_flagN                 = flag_n_q;
  assign bus.o_flagZ                 = flag_z_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random instruction streams
// compared against a per-step table model built from the instruction set description.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic model_fn, model_fz;

  always #5 clk = ~clk;

  control_sequencer_if bus();

  control_sequencer dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       alu_oe;
    logic       alu_sub;
    logic [1:0] alu_op;
    logic       alu_bwr;
    logic       shl;
    logic       wr0;
    logic       wr1;
    logic       bsel;
    logic       ben;
    logic       asel;
    logic       raddr;
    logic       rwe;
    logic       rrd;
    logic       roe;
    logic       drv;
    logic [7:0] val;
    logic       done;
    logic       illegal;
    logic       ready;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.alu_oe  = bus.o_ctrlAluOE;
    o.alu_sub = bus.o_ctrlAluSub;
    o.alu_op  = bus.o_ctrlAluOp;
    o.alu_bwr = bus.o_ctrlAluBWr;
    o.shl     = bus.o_ctrlAluShiftLeft;
    o.wr0     = bus.o_ctrlRegWr0;
    o.wr1     = bus.o_ctrlRegWr1;
    o.bsel    = bus.o_ctrlRegBusSel;
    o.ben     = bus.o_ctrlRegBusEn;
    o.asel    = bus.o_ctrlAluSel;
    o.raddr   = bus.o_ctrlRamAddressEn;
    o.rwe     = bus.o_ctrlRamWriteEn;
    o.rrd     = bus.o_ctrlRamReadDataSelect;
    o.roe     = bus.o_ctrlRamOE;
    o.drv     = bus.o_busDrive;
    o.val     = bus.o_busValue;
    o.done    = bus.o_done;
    o.illegal = bus.o_illegal;
    o.ready   = bus.o_instrReady;
    return o;
  endfunction

  function automatic bit legal(input int op);
`ifdef CTRL_SEQ_SHIFT_EN
    return (op >= 0 && op <= 9);
`else
    return (op >= 0 && op <= 5) || op == 8 || op == 9;
`endif
  endfunction

  function automatic bit is_alu(input int op);
    return legal(op) && op >= 2 && op <= 7;
  endfunction

  function automatic int nsteps(input int op);
    if (!legal(op))      return 1;
    else if (op <= 1)    return 1;
    else if (op <= 7)    return 3;
    else                 return 2;
  endfunction

  // Expected outputs during step k of an instruction, straight from the instruction table
  function automatic obs_t expect_out(input int op, input logic rd, input logic rs,
                                      input logic [7:0] imm, input int k);
    obs_t e;
    e = '0;
    if (!legal(op)) begin
      e.illegal = 1'b1;
      return e;
    end
    e.done = (k == nsteps(op));
    if (op == 1) begin
      e.drv = 1'b1; e.val = imm; e.wr0 = ~rd; e.wr1 = rd;
    end else if (is_alu(op)) begin
      if (k == 1) begin
        e.drv = 1'b1; e.val = imm; e.alu_bwr = 1'b1; e.asel = rs;
      end else begin
        e.asel = rs;
        if (op == 3) e.alu_sub = 1'b1;
        if (op == 4) e.alu_op = 2'b01;
        if (op == 5) e.alu_op = 2'b10;
        if (op == 6 || op == 7) e.alu_op = 2'b11;
        if (op == 7) e.shl = 1'b1;
        if (k == 3) begin
          e.alu_oe = 1'b1; e.wr0 = ~rd; e.wr1 = rd;
        end
      end
    end else if (op == 9) begin
      e.ben = 1'b1;
      if (k == 1) begin e.bsel = rd; e.raddr = 1'b1; end
      else        begin e.bsel = rs; e.rwe = 1'b1; end
    end else if (op == 8) begin
      if (k == 1) begin e.bsel = rs; e.ben = 1'b1; e.raddr = 1'b1; end
      else        begin e.rrd = 1'b1; e.roe = 1'b1; e.wr0 = ~rd; e.wr1 = rd; end
    end
    return e;
  endfunction

  // Called at a falling edge while IDLE; returns at the falling edge of the following IDLE cycle
  task automatic run_instr(input string name, input int op, input logic rd, input logic rs,
                           input logic [7:0] imm, input logic fn, input logic fz);
    obs_t        got, exp;
    int          n;
    logic [31:0] r;
    logic [3:0]  opc;
    exp = '0; exp.ready = 1'b1;
    got = sample();
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s idle: got %h expected %h", name, got, exp); end
    r = $urandom;
    opc = op[3:0];
    bus.i_instrValid = 1'b1;
    bus.i_instr      = {opc, rd, rs, r[1:0], imm};
    @(negedge clk);
    bus.i_instrValid = 1'b0;
    bus.i_instr      = r[31:16];
    n = nsteps(op);
    for (int k = 1; k <= n; k++) begin
      exp = expect_out(op, rd, rs, imm, k);
      got = sample();
      total++;
      if (got !== exp) begin bad++; $display("FAIL %s step%0d: got %h expected %h", name, k, got, exp); end
      total++;
      if ({bus.o_flagN, bus.o_flagZ} !== {model_fn, model_fz}) begin
        bad++; $display("FAIL %s flags_step%0d: got %b%b expected %b%b", name, k, bus.o_flagN, bus.o_flagZ, model_fn, model_fz);
      end
      r = $urandom;
      bus.i_instr = r[31:16];
      if (is_alu(op) && k == 3) begin
        bus.i_aluFlagN = fn; bus.i_aluFlagZ = fz; model_fn = fn; model_fz = fz;
      end else begin
        bus.i_aluFlagN = r[0]; bus.i_aluFlagZ = r[1];
      end
      @(negedge clk);
    end
    total++;
    if ({bus.o_flagN, bus.o_flagZ} !== {model_fn, model_fz}) begin
      bad++; $display("FAIL %s flags_after: got %b%b expected %b%b", name, bus.o_flagN, bus.o_flagZ, model_fn, model_fz);
    end
  endtask

  task automatic test_reset();
    obs_t exp;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp = '0; exp.ready = 1'b1;
    total++;
    if (sample() !== exp || bus.o_flagN !== 1'b0 || bus.o_flagZ !== 1'b0) begin
      bad++; $display("FAIL reset_state: got %h flags %b%b expected %h flags 00", sample(), bus.o_flagN, bus.o_flagZ, exp);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi();
    run_instr("ldi_2a", 1, 1'b0, 1'b0, 8'h2a, 1'b0, 1'b0);
    run_instr("ldi_rd1", 1, 1'b1, 1'b0, 8'hc5, 1'b1, 1'b1);
  endtask

  task automatic test_alu();
    run_instr("shr", 6, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    run_instr("shl", 7, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    run_instr("add", 2, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1);
    run_instr("sub", 3, 1'b1, 1'b1, 8'hfe, 1'b0, 1'b0);
    run_instr("and", 4, 1'b0, 1'b0, 8'h0f, 1'b1, 1'b0);
    run_instr("or", 5, 1'b1, 1'b0, 8'hf0, 1'b0, 1'b1);
    run_instr("nop", 0, 1'b1, 1'b1, 8'hff, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    run_instr("st", 9, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    run_instr("ld", 8, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
    total++;
    if (cyc - start !== 6) begin bad++; $display("FAIL b2b_cycles: got %0d expected 6", cyc - start); end
  endtask

  task automatic test_illegal();
    run_instr("illegal_c", 12, 1'b1, 1'b0, 8'h5a, 1'b0, 1'b0);
    run_instr("illegal_f", 15, 1'b0, 1'b1, 8'ha5, 1'b0, 1'b0);
    run_instr("ldi_after_illegal", 1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    obs_t exp;
    run_instr("add_setflags", 2, 1'b0, 1'b0, 8'h07, 1'b1, 1'b1);
    bus.i_instrValid = 1'b1;
    bus.i_instr      = {4'd2, 1'b1, 1'b0, 2'b00, 8'h09};
    @(negedge clk);
    bus.i_instrValid = 1'b0;
    @(negedge clk);
    exp = expect_out(2, 1'b1, 1'b0, 8'h09, 2);
    total++;
    if (sample() !== exp) begin bad++; $display("FAIL rstmid_s2: got %h expected %h", sample(), exp); end
    rst = 1'b1;
    @(negedge clk);
    exp = '0; exp.ready = 1'b1;
    total++;
    if (sample() !== exp || bus.o_flagN !== 1'b0 || bus.o_flagZ !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: got %h flags %b%b expected %h flags 00", sample(), bus.o_flagN, bus.o_flagZ, exp);
    end
    rst = 1'b0;
    model_fn = 1'b0; model_fz = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      run_instr("random", int'(r[3:0]), r[4], r[5], r[15:8], r[16], r[17]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_instrValid = 1'b0;
    bus.i_instr      = 16'h0000;
    bus.i_aluFlagN   = 1'b0;
    bus.i_aluFlagZ   = 1'b0;
    model_fn = 1'b0;
    model_fz = 1'b0;
    @(negedge clk);
    test_reset();
    test_ldi();
    test_alu();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
